// File: rtl/ws2811_pkg.sv
// Shared types and timing helpers for the WS2811/WS2812 pixel transmitter.
package ws2811_pkg;

    typedef enum logic [2:0] {
        ST_LATCH,
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_e;

    localparam int unsigned T0H_NS_SLOW  = 500;
    localparam int unsigned T1H_NS_SLOW  = 1200;
    localparam int unsigned TBIT_NS_SLOW = 2500;
    localparam int unsigned T0H_NS_FAST  = 250;
    localparam int unsigned T1H_NS_FAST  = 600;
    localparam int unsigned TBIT_NS_FAST = 1250;

    // Whole clock cycles in a duration, never less than one.
    function automatic int unsigned ns_to_cyc(input longint unsigned clk_hz,
                                              input longint unsigned ns);
        longint unsigned c;
        c = (clk_hz * ns) / 64'd1_000_000_000;
        return (c == 64'd0) ? 32'd1 : 32'(c);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2811_bit_timer.sv
// Loadable down-counter that parks at zero; shared by the HIGH, LOW and LATCH phases.
module ws2811_bit_timer #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= RST_VAL;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ws2811_pixel_tx.sv
// WS2811/WS2812 single-wire transmitter: streams pixel words MSB-first as NRZ
// pulses, then holds the line low for the latch period after NUM_PIXELS pixels.
module ws2811_pixel_tx
    import ws2811_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FAST_MODE  = 0,
    parameter int unsigned PIXEL_W    = 24,
    parameter int unsigned NUM_PIXELS = 50,
    parameter int unsigned LATCH_NS   = 50_000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_valid,
    output logic               pixel_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun,
    output logic               signal
);

    localparam int unsigned T0H_NS  = (FAST_MODE != 0) ? T0H_NS_FAST  : T0H_NS_SLOW;
    localparam int unsigned T1H_NS  = (FAST_MODE != 0) ? T1H_NS_FAST  : T1H_NS_SLOW;
    localparam int unsigned TBIT_NS = (FAST_MODE != 0) ? TBIT_NS_FAST : TBIT_NS_SLOW;

    localparam int unsigned T0H_C   = ns_to_cyc(64'(CLK_HZ), 64'(T0H_NS));
    localparam int unsigned T1H_C   = ns_to_cyc(64'(CLK_HZ), 64'(T1H_NS));
    localparam int unsigned TBIT_C  = ns_to_cyc(64'(CLK_HZ), 64'(TBIT_NS));
    localparam int unsigned LATCH_C = ns_to_cyc(64'(CLK_HZ), 64'(LATCH_NS));

    localparam int unsigned TMR_W = $clog2(max_u(LATCH_C, TBIT_C) + 1);
    localparam int unsigned CNT_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int unsigned IDX_W = (PIXEL_W > 1) ? $clog2(PIXEL_W) : 1;

    // Timer reloads are "duration - 1" so each phase lasts exactly its cycle count.
    localparam logic [TMR_W-1:0] T0H_LD   = TMR_W'(T0H_C - 1);
    localparam logic [TMR_W-1:0] T1H_LD   = TMR_W'(T1H_C - 1);
    localparam logic [TMR_W-1:0] T0L_LD   = TMR_W'(TBIT_C - T0H_C - 1);
    localparam logic [TMR_W-1:0] T1L_LD   = TMR_W'(TBIT_C - T1H_C - 1);
    localparam logic [TMR_W-1:0] LATCH_LD = TMR_W'(LATCH_C - 1);

    if (T1H_C >= TBIT_C) begin : g_bad_timing
        $error("ws2811_pixel_tx: T1H_C must be shorter than TBIT_C");
    end
    if (NUM_PIXELS < 1) begin : g_bad_count
        $error("ws2811_pixel_tx: NUM_PIXELS must be at least 1");
    end

    state_e             state_q;
    logic [PIXEL_W-1:0] shift_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               signal_q;
    logic               frame_done_q;
    logic               underrun_q;

    logic               tmr_zero;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               last_bit;
    logic               last_pix;
    logic               ready;
    logic               xfer;

    function automatic logic [TMR_W-1:0] high_ld(input logic b);
        return b ? T1H_LD : T0H_LD;
    endfunction

    assign last_bit = (idx_q == '0);
    assign last_pix = (cnt_q == CNT_W'(NUM_PIXELS - 1));
    assign ready    = (state_q == ST_IDLE) || (state_q == ST_GAP) ||
                      ((state_q == ST_LOW) && last_bit && tmr_zero);
    assign xfer     = pixel_valid && ready;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = LATCH_LD;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (xfer) begin
                    tmr_load = 1'b1;
                    tmr_val  = high_ld(pixel_data[PIXEL_W-1]);
                end
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = shift_q[PIXEL_W-1] ? T1L_LD : T0L_LD;
                end
            end
            ST_LOW: begin
                if (tmr_zero) begin
                    if (!last_bit) begin
                        tmr_load = 1'b1;
                        tmr_val  = high_ld(shift_q[PIXEL_W-2]);
                    end else if (xfer) begin
                        tmr_load = 1'b1;
                        tmr_val  = high_ld(pixel_data[PIXEL_W-1]);
                    end else if (last_pix) begin
                        tmr_load = 1'b1;
                        tmr_val  = LATCH_LD;
                    end
                end
            end
            default: ;
        endcase
    end

    ws2811_bit_timer #(
        .WIDTH   (TMR_W),
        .RST_VAL (LATCH_LD)
    ) u_timer (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_LATCH;
            shift_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            signal_q     <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            case (state_q)
                ST_LATCH: begin
                    if (tmr_zero) begin
                        state_q      <= ST_IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (xfer) begin
                        shift_q  <= pixel_data;
                        idx_q    <= IDX_W'(PIXEL_W - 1);
                        cnt_q    <= '0;
                        state_q  <= ST_HIGH;
                        signal_q <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (tmr_zero) begin
                        state_q  <= ST_LOW;
                        signal_q <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (tmr_zero) begin
                        if (!last_bit) begin
                            shift_q  <= shift_q << 1;
                            idx_q    <= idx_q - IDX_W'(1);
                            state_q  <= ST_HIGH;
                            signal_q <= 1'b1;
                        end else if (xfer) begin
                            shift_q  <= pixel_data;
                            idx_q    <= IDX_W'(PIXEL_W - 1);
                            cnt_q    <= cnt_q + CNT_W'(1);
                            state_q  <= ST_HIGH;
                            signal_q <= 1'b1;
                        end else if (last_pix) begin
                            state_q <= ST_LATCH;
                        end else begin
                            state_q    <= ST_GAP;
                            underrun_q <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (xfer) begin
                        shift_q  <= pixel_data;
                        idx_q    <= IDX_W'(PIXEL_W - 1);
                        cnt_q    <= cnt_q + CNT_W'(1);
                        state_q  <= ST_HIGH;
                        signal_q <= 1'b1;
                    end
                end
                default: state_q <= ST_LATCH;
            endcase
        end
    end

    assign pixel_ready = ready;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;
    assign signal      = signal_q;

endmodule

// File: tb/tb_ws2811_pixel_tx.sv
// Bench for ws2811_pixel_tx: pulse-edge monitor checked against an arithmetic
// model of bit start times, high widths, underrun and frame_done timing.
module tb_ws2811_pixel_tx;

    localparam int unsigned T0H    = 25;
    localparam int unsigned T1H    = 60;
    localparam int unsigned TBIT   = 125;
    localparam int unsigned LATCH  = 2500;
    localparam int unsigned NBITS  = 24;
    localparam int unsigned F_T1H  = 30;
    localparam int unsigned F_TBIT = 62;
    localparam int unsigned F_BITS = 32;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [23:0] s_data;
    logic        s_valid;
    logic        s_ready, s_busy, s_fd, s_ur, s_sig;
    logic [31:0] f_data;
    logic        f_valid;
    logic        f_ready, f_busy, f_fd, f_ur, f_sig;

    always #5 Clock = ~Clock;

    ws2811_pixel_tx #(
        .CLK_HZ(50_000_000), .FAST_MODE(0), .PIXEL_W(24), .NUM_PIXELS(2), .LATCH_NS(50_000)
    ) dut (
        .Clock(Clock), .Reset(Reset), .pixel_data(s_data), .pixel_valid(s_valid),
        .pixel_ready(s_ready), .busy(s_busy), .frame_done(s_fd), .underrun(s_ur), .signal(s_sig)
    );

    ws2811_pixel_tx #(
        .CLK_HZ(50_000_000), .FAST_MODE(1), .PIXEL_W(32), .NUM_PIXELS(1), .LATCH_NS(50_000)
    ) dut_f (
        .Clock(Clock), .Reset(Reset), .pixel_data(f_data), .pixel_valid(f_valid),
        .pixel_ready(f_ready), .busy(f_busy), .frame_done(f_fd), .underrun(f_ur), .signal(f_sig)
    );

    longint cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Edge monitor on whichever instance is selected.
    bit     use_fast = 1'b0;
    logic   mon_prev = 1'b0;
    longint last_rise = 0;
    longint rise_q[$], width_q[$], fd_q[$], ur_q[$];
    logic   mon_sig, mon_fd, mon_ur;
    assign mon_sig = use_fast ? f_sig : s_sig;
    assign mon_fd  = use_fast ? f_fd  : s_fd;
    assign mon_ur  = use_fast ? f_ur  : s_ur;

    always @(negedge Clock) begin
        if (mon_sig === 1'b1 && mon_prev === 1'b0) begin
            rise_q.push_back(cyc);
            last_rise = cyc;
        end
        if (mon_sig === 1'b0 && mon_prev === 1'b1) width_q.push_back(cyc - last_rise);
        if (mon_fd === 1'b1) fd_q.push_back(cyc);
        if (mon_ur === 1'b1) ur_q.push_back(cyc);
        mon_prev = mon_sig;
    end

    task automatic clear_mon();
        rise_q.delete(); width_q.delete(); fd_q.delete(); ur_q.delete();
    endtask

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present a word and hold it until accepted; t is the accepting edge.
    task automatic send(input logic [31:0] d, output longint t, output bit ok);
        ok = 1'b0;
        if (use_fast) begin f_data = d; f_valid = 1'b1; end
        else begin s_data = d[23:0]; s_valid = 1'b1; end
        for (int i = 0; i < 6000; i++) begin
            @(negedge Clock);
            if ((use_fast ? f_ready : s_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge Clock); #1;
        t = cyc;
        f_valid = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic wait_fd(input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < int'(budget); i++) begin
            @(posedge Clock); #1;
            if (fd_q.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts non-ready cycles after a reset edge, watching the line and frame_done.
    task automatic measure_latch(output int n, output bit sig_hi, output bit fd_seen,
                                 output logic first_sig, output logic first_busy,
                                 output logic first_ready);
        n = 0; sig_hi = 1'b0; fd_seen = 1'b0;
        first_sig = 1'bx; first_busy = 1'bx; first_ready = 1'bx;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clock);
            if (i == 0) begin
                first_sig = s_sig; first_busy = s_busy; first_ready = s_ready;
            end
            if (s_ready === 1'b1) break;
            n++;
            if (s_sig !== 1'b0) sig_hi = 1'b1;
            if (s_fd === 1'b1) fd_seen = 1'b1;
        end
    endtask

    // Two-pixel frame with pixel 2 offered d cycles after pixel 1 is accepted.
    task automatic run_frame(input string tag, input logic [23:0] p0, input logic [23:0] p1,
                             input int unsigned d, input int unsigned exp_ur);
        longint t0, t1, s1, exp_rise;
        bit ok0, ok1, okf, b;
        logic [23:0] px;
        @(posedge Clock); #1;
        clear_mon();
        send({8'h00, p0}, t0, ok0);
        repeat (d) @(posedge Clock);
        #1;
        send({8'h00, p1}, t1, ok1);
        s1 = ((d + 1) > NBITS * TBIT) ? t0 + d + 1 : t0 + NBITS * TBIT;
        wait_fd(7000, okf);
        repeat (20) @(posedge Clock);
        #1;
        chk({tag, " accept0"}, ok0, 1);
        chk({tag, " accept1"}, ok1, 1);
        chk({tag, " frame_done seen"}, okf, 1);
        chk({tag, " pixel2 start"}, t1, s1);
        chk({tag, " rise count"}, rise_q.size(), 2 * NBITS);
        chk({tag, " width count"}, width_q.size(), 2 * NBITS);
        for (int i = 0; i < int'(2 * NBITS) && i < rise_q.size() && i < width_q.size(); i++) begin
            px = (i < int'(NBITS)) ? p0 : p1;
            b = px[int'(NBITS) - 1 - (i % int'(NBITS))];
            exp_rise = ((i < int'(NBITS)) ? t0 : s1) + (i % int'(NBITS)) * TBIT;
            chk($sformatf("%s rise%0d", tag, i), rise_q[i], exp_rise);
            chk($sformatf("%s width%0d", tag, i), width_q[i], b ? T1H : T0H);
        end
        chk({tag, " underrun count"}, ur_q.size(), exp_ur);
        if (ur_q.size() != 0) chk({tag, " underrun time"}, ur_q[0], t0 + NBITS * TBIT);
        chk({tag, " frame_done count"}, fd_q.size(), 1);
        if (fd_q.size() != 0) chk({tag, " frame_done time"}, fd_q[0], s1 + NBITS * TBIT + LATCH);
    endtask

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        int unsigned delay;
        int unsigned exp_ur;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit sig_hi, fd_seen, busy_lo, ok, rand_ur;
        logic fs, fb, fr;
        longint t0;
        logic [23:0] rp0, rp1;
        int unsigned rd;

        vecs[0] = '{24'hA50000, 24'h00000F, 0,    0};
        vecs[1] = '{24'hFF00FF, 24'h5A5A5A, 2999, 0};
        vecs[2] = '{24'h000001, 24'h800000, 3000, 1};
        vecs[3] = '{24'h123456, 24'hFEDCBA, 3299, 1};

        Reset = 1'b1; s_valid = 1'b0; f_valid = 1'b0; s_data = '0; f_data = '0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        chk("reset ready", s_ready, 0);
        chk("reset busy", s_busy, 1);
        chk("reset signal", s_sig, 0);
        chk("reset frame_done", s_fd, 0);
        chk("reset underrun", s_ur, 0);
        chk("reset fast ready", f_ready, 0);

        // Reset release: full latch period of low line before ready.
        @(posedge Clock); #1;
        Reset = 1'b0;
        clear_mon();
        measure_latch(n, sig_hi, fd_seen, fs, fb, fr);
        chk("release ready delay", n, LATCH);
        chk("release signal low", sig_hi, 0);

        // Idle with no valid: nothing happens.
        busy_lo = 1'b1;
        sig_hi  = 1'b0;
        clear_mon();
        repeat (200) begin
            @(negedge Clock);
            if (s_busy !== 1'b0) busy_lo = 1'b0;
            if (s_sig !== 1'b0 || s_ready !== 1'b1) sig_hi = 1'b1;
        end
        chk("idle busy low", busy_lo, 1);
        chk("idle quiet", sig_hi, 0);
        chk("idle rises", rise_q.size(), 0);

        foreach (vecs[i])
            run_frame($sformatf("vec%0d", i), vecs[i].p0, vecs[i].p1, vecs[i].delay, vecs[i].exp_ur);

        for (int r = 0; r < 2; r++) begin
            rp0 = 24'($urandom);
            rp1 = 24'($urandom);
            rd  = $urandom_range(0, 3400);
            rand_ur = ((rd + 1) > NBITS * TBIT);
            run_frame($sformatf("rand%0d", r), rp0, rp1, rd, {31'd0, rand_ur});
        end

        // Reset during the tenth bit's high phase.
        @(posedge Clock); #1;
        clear_mon();
        send(32'h00FFFFFF, t0, ok);
        chk("midreset accept", ok, 1);
        for (int i = 0; i < 3000 && rise_q.size() < 10; i++) begin
            @(posedge Clock); #1;
        end
        repeat (5) @(posedge Clock);
        #1;
        chk("midreset signal high before", s_sig, 1);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        measure_latch(n, sig_hi, fd_seen, fs, fb, fr);
        chk("midreset signal next", fs, 0);
        chk("midreset busy next", fb, 1);
        chk("midreset ready next", fr, 0);
        chk("midreset ready delay", n, LATCH);
        chk("midreset signal low", sig_hi, 0);
        chk("midreset no frame_done", fd_seen, 0);
        chk("midreset rises", rise_q.size(), 10);

        // Fast mode, 32-bit single-pixel frame.
        @(posedge Clock); #1;
        use_fast = 1'b1;
        @(posedge Clock); #1;
        clear_mon();
        send(32'hFFFF_FFFF, t0, ok);
        chk("fast accept", ok, 1);
        wait_fd(F_BITS * F_TBIT + LATCH + 200, ok);
        repeat (20) @(posedge Clock);
        #1;
        chk("fast frame_done seen", ok, 1);
        chk("fast rise count", rise_q.size(), F_BITS);
        chk("fast width count", width_q.size(), F_BITS);
        for (int i = 0; i < int'(F_BITS) && i < rise_q.size() && i < width_q.size(); i++) begin
            chk($sformatf("fast rise%0d", i), rise_q[i], t0 + i * F_TBIT);
            chk($sformatf("fast width%0d", i), width_q[i], F_T1H);
        end
        chk("fast underrun count", ur_q.size(), 0);
        chk("fast frame_done count", fd_q.size(), 1);
        if (fd_q.size() != 0) chk("fast frame_done time", fd_q[0], t0 + F_BITS * F_TBIT + LATCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
